// File: rtl/palette_pkg.sv
// Shared definitions for the palette write arbiter.
//   IDX_W / COLOR_W : default palette index and colour widths
//   state_e         : write FSM states
//   DEFAULT_PALETTE : colours loaded into the lowest entries on reset
//   default_color() : reset colour for any palette index
package palette_pkg;

  localparam int unsigned IDX_W     = 5;
  localparam int unsigned COLOR_W   = 24;
  localparam int unsigned N_DEFAULT = 5;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } state_e;

  // Colours are packed {R, G, B}.
  localparam logic [COLOR_W-1:0] DEFAULT_PALETTE [N_DEFAULT] = '{
    24'h3F007F,
    24'hFFFFFF,
    24'hFF0000,
    24'h00FF00,
    24'hFF00FF
  };

  function automatic logic [COLOR_W-1:0] default_color(int unsigned idx);
    if (idx < N_DEFAULT) begin
      return DEFAULT_PALETTE[idx];
    end
    return '0;
  endfunction

endpackage

// File: rtl/palette_arbiter_if.sv
// Bus bundle between palette-write requesters / pixel pipeline and the arbiter.
//   vblank  : vertical blanking, the only window where writes are granted
//   wr_req  : per-requester write request
//   wr_idx  : per-requester palette index, slice k belongs to requester k
//   wr_rgb  : per-requester colour, slice k belongs to requester k
//   wr_ack  : one-cycle one-hot commit acknowledge
//   obj_id  : object code of the current pixel
//   rgb_out : registered palette colour for obj_id
//   busy    : arbiter is not idle
interface palette_arbiter_if import palette_pkg::*; #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned IDX_W   = palette_pkg::IDX_W,
  parameter int unsigned COLOR_W = palette_pkg::COLOR_W
) ();

  logic                       vblank;
  logic [N_REQ-1:0]           wr_req;
  logic [N_REQ*IDX_W-1:0]     wr_idx;
  logic [N_REQ*COLOR_W-1:0]   wr_rgb;
  logic [N_REQ-1:0]           wr_ack;
  logic [IDX_W-1:0]           obj_id;
  logic [COLOR_W-1:0]         rgb_out;
  logic                       busy;

  modport master (
    output vblank, wr_req, wr_idx, wr_rgb, obj_id,
    input  wr_ack, rgb_out, busy
  );

  modport slave (
    input  vblank, wr_req, wr_idx, wr_rgb, obj_id,
    output wr_ack, rgb_out, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
//   req   : request vector
//   last  : most recently served requester
//   grant : first requester at or after last+1 (with wrap) that is requesting
//   valid : at least one request is present
module rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] grant,
  output logic             valid
);

  logic [SEL_W-1:0] pos;

  // Scan from the farthest offset down to +1 so the nearest requester after
  // last is the final (winning) assignment.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    pos   = '0;
    for (int ofs = N_REQ; ofs > 0; ofs--) begin
      pos = SEL_W'((int'(last) + ofs) % N_REQ);
      if (req[pos]) begin
        grant = pos;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Colour palette with round-robin arbitrated writes during vertical blanking.
//   clk   : single clock
//   rst_n : synchronous active-low reset; reloads the default palette
//   bus   : slave side of palette_arbiter_if (write requests, pixel lookup)
// A grant latches the requester's index and colour in IDLE; the following
// WRITE cycle commits it and acknowledges, giving one write per two cycles.
module palette_arbiter import palette_pkg::*; #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned IDX_W   = palette_pkg::IDX_W,
  parameter int unsigned COLOR_W = palette_pkg::COLOR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  palette_arbiter_if.slave  bus
);

  localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DEPTH = 1 << IDX_W;

  state_e state_q, state_d;

  logic [SEL_W-1:0]   grant_q;
  logic [SEL_W-1:0]   last_q;
  logic [SEL_W-1:0]   arb_grant;
  logic               arb_valid;
  logic [IDX_W-1:0]   idx_q;
  logic [COLOR_W-1:0] wr_rgb_q;
  logic [COLOR_W-1:0] rgb_out_q;
  logic [COLOR_W-1:0] palette_q [DEPTH];

  logic               latch_en;
  logic               commit_en;
  logic [N_REQ-1:0]   wr_ack;
  logic               busy;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req   (bus.wr_req),
    .last  (last_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.vblank && arb_valid) state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on registered state, so wr_ack cannot glitch.
  always_comb begin
    latch_en  = 1'b0;
    commit_en = 1'b0;
    wr_ack    = '0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        latch_en = bus.vblank && arb_valid;
      end
      StWrite: begin
        commit_en       = 1'b1;
        busy            = 1'b1;
        wr_ack[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Granted request is captured once, so later wr_req changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q  <= '0;
      idx_q    <= '0;
      wr_rgb_q <= '0;
      last_q   <= SEL_W'(N_REQ - 1);
    end else begin
      if (latch_en) begin
        grant_q  <= arb_grant;
        idx_q    <= bus.wr_idx[arb_grant*IDX_W +: IDX_W];
        wr_rgb_q <= bus.wr_rgb[arb_grant*COLOR_W +: COLOR_W];
      end
      if (commit_en) begin
        last_q <= grant_q;
      end
    end
  end

  // Palette storage and lookup register. The lookup samples the array before
  // this cycle's commit lands, giving read-before-write on a shared index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        palette_q[i] <= COLOR_W'(default_color(i));
      end
      rgb_out_q <= '0;
    end else begin
      rgb_out_q <= palette_q[bus.obj_id];
      if (commit_en) begin
        palette_q[idx_q] <= wr_rgb_q;
      end
    end
  end

  assign bus.wr_ack  = wr_ack;
  assign bus.busy    = busy;
  assign bus.rgb_out = rgb_out_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Scoreboard bench for palette_arbiter: a per-cycle reference model pushes the
// expected {rgb_out, wr_ack, busy} each clock; a monitor pops and compares on
// the falling edge. Directed phases cover the called-out scenarios, then a
// randomized phase exercises arbitration, vblank gating and lookups.
module tb_palette_arbiter;

  localparam int N_REQ   = 2;
  localparam int IDX_W   = 5;
  localparam int COLOR_W = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  palette_arbiter_if #(.N_REQ(N_REQ), .IDX_W(IDX_W), .COLOR_W(COLOR_W)) bus ();

  palette_arbiter #(
    .N_REQ   (N_REQ),
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [COLOR_W-1:0] rgb;
    logic [N_REQ-1:0]   ack;
    logic               busy;
  } exp_t;

  exp_t               sb_q [$];
  logic [COLOR_W-1:0] m_pal [32];
  int                 m_last;
  bit                 m_pending;
  int                 m_grant;
  int                 m_k;
  bit                 m_found;
  logic [IDX_W-1:0]   m_idx;
  logic [COLOR_W-1:0] m_rgb;
  exp_t               m_exp;

  always @(posedge clk) begin
    m_exp = '0;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_pal[i] = '0;
      m_pal[0]  = 24'h3F007F;
      m_pal[1]  = 24'hFFFFFF;
      m_pal[2]  = 24'hFF0000;
      m_pal[3]  = 24'h00FF00;
      m_pal[4]  = 24'hFF00FF;
      m_last    = N_REQ - 1;
      m_pending = 1'b0;
    end else begin
      m_exp.rgb = m_pal[bus.obj_id];
      if (m_pending) begin
        m_pal[m_idx] = m_rgb;
        m_last       = m_grant;
        m_pending    = 1'b0;
      end else if (bus.vblank && (bus.wr_req != '0)) begin
        m_found = 1'b0;
        for (int s = 1; s <= N_REQ; s++) begin
          m_k = (m_last + s) % N_REQ;
          if (!m_found && bus.wr_req[m_k]) begin
            m_grant = m_k;
            m_found = 1'b1;
          end
        end
        m_idx     = bus.wr_idx[m_grant*IDX_W +: IDX_W];
        m_rgb     = bus.wr_rgb[m_grant*COLOR_W +: COLOR_W];
        m_pending = 1'b1;
      end
      m_exp.busy = m_pending;
      if (m_pending) m_exp.ack[m_grant] = 1'b1;
    end
    sb_q.push_back(m_exp);
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_rgb_out", 32'(bus.rgb_out), 32'(mon_e.rgb));
      chk("sb_wr_ack", 32'(bus.wr_ack), 32'(mon_e.ack));
      chk("sb_busy", 32'(bus.busy), 32'(mon_e.busy));
    end
  end

  // ---------------- stimulus ----------------
  logic [N_REQ-1:0] ack_s;
  bit               auto_drop = 1'b1;

  // One clock: sample ack mid-cycle, then act just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    ack_s = bus.wr_ack;
    @(posedge clk);
    #1;
    if (auto_drop) begin
      for (int k = 0; k < N_REQ; k++) if (ack_s[k]) bus.wr_req[k] = 1'b0;
    end
  endtask

  task automatic set_req(int k, logic [IDX_W-1:0] idx, logic [COLOR_W-1:0] rgb);
    bus.wr_idx[k*IDX_W +: IDX_W]     = idx;
    bus.wr_rgb[k*COLOR_W +: COLOR_W] = rgb;
    bus.wr_req[k]                    = 1'b1;
  endtask

  logic [N_REQ-1:0]   pat [8];
  bit                 got;
  logic [COLOR_W-1:0] rnd_rgb;

  initial begin
    bus.vblank = 1'b0;
    bus.wr_req = '0;
    bus.wr_idx = '0;
    bus.wr_rgb = '0;
    bus.obj_id = '0;

    // Reset defaults visible one cycle after lookup.
    repeat (3) cyc();
    rst_n      = 1'b1;
    bus.obj_id = 5'd2;
    cyc();
    chk("rst_obj2", 32'(bus.rgb_out), 32'hFF0000);
    bus.obj_id = 5'd0;
    cyc();
    chk("rst_obj0", 32'(bus.rgb_out), 32'h3F007F);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // Single write from requester 0, then read back.
    bus.vblank = 1'b1;
    set_req(0, 5'd2, 24'h00FFFF);
    cyc();
    chk("w0_ack", 32'(bus.wr_ack), 32'h1);
    cyc();
    chk("w0_ack_one_cycle", 32'(bus.wr_ack), 32'h0);
    bus.obj_id = 5'd2;
    cyc();
    chk("w0_readback", 32'(bus.rgb_out), 32'h00FFFF);

    // Both requesters holding: alternating acks with an idle cycle between.
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n     = 1'b1;
    auto_drop = 1'b0;
    set_req(0, 5'd10, 24'h112233);
    set_req(1, 5'd11, 24'h445566);
    pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("rr_ack%0d", i), 32'(bus.wr_ack), 32'(pat[i]));
    end
    bus.wr_req = '0;
    bus.vblank = 1'b0;
    auto_drop  = 1'b1;

    // Request outside vblank waits, then is served once vblank rises.
    set_req(1, 5'd12, 24'hABCDEF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("novb_ack", 32'(bus.wr_ack), 32'h0);
      chk("novb_busy", 32'(bus.busy), 32'h0);
    end
    bus.vblank = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      cyc();
      if (bus.wr_ack[1]) got = 1'b1;
    end
    chk("vb_rise_ack", 32'(got), 32'h1);
    repeat (2) cyc();

    // Latch in the last vblank cycle still commits.
    set_req(0, 5'd7, 24'h5A5AA5);
    cyc();
    bus.vblank = 1'b0;
    chk("late_ack", 32'(bus.wr_ack), 32'h1);
    cyc();
    bus.obj_id = 5'd7;
    cyc();
    chk("late_readback", 32'(bus.rgb_out), 32'h5A5AA5);

    // Reset during WRITE aborts the commit.
    bus.vblank = 1'b1;
    set_req(0, 5'd3, 24'h123456);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("rstw_ack", 32'(bus.wr_ack), 32'h0);
    rst_n      = 1'b1;
    bus.wr_req = '0;
    bus.obj_id = 5'd3;
    cyc();
    chk("rstw_entry3", 32'(bus.rgb_out), 32'h00FF00);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      cyc();
      if ($urandom_range(0, 7) == 0) bus.vblank = ~bus.vblank;
      bus.obj_id = 5'($urandom_range(0, 31));
      for (int k = 0; k < N_REQ; k++) begin
        if (!bus.wr_req[k] && !ack_s[k] && $urandom_range(0, 3) == 0) begin
          rnd_rgb = 24'($urandom);
          set_req(k, 5'($urandom_range(0, 31)), rnd_rgb);
        end
      end
    end

    bus.wr_req = '0;
    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/palette_arbiter.md
PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001: Parameter N_REQ, default 2, SHALL set the number of palette-write requesters.
REQ-002: Parameter IDX_W, default 5, SHALL set the object-ID / palette-index width (32 entries).
REQ-003: Parameter COLOR_W, default 24, SHALL set the RGB width, packed {R[23:16],G[15:8],B[7:0]}.
REQ-004: Clk  input  1  SHALL be the single clock.
REQ-005: Reset  input  1  SHALL be the reset, synchronous and active-low.
REQ-006: vblank  input  1  SHALL be high during vertical blanking, the only window in which new writes are granted.
REQ-007: wr_req  input  N_REQ  SHALL carry per-requester write requests.
REQ-008: wr_idx  input  N_REQ*IDX_W  SHALL carry per-requester target indices; requester k uses slice k.
REQ-009: wr_rgb  input  N_REQ*COLOR_W  SHALL carry per-requester colours; requester k uses slice k.
REQ-010: wr_ack  output  N_REQ  SHALL give a one-cycle, one-hot commit acknowledge.
REQ-011: obj_id  input  IDX_W  SHALL give the object code of the current pixel.
REQ-012: rgb_out  output  COLOR_W  SHALL give the registered palette colour for obj_id.
REQ-013: busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-014: The palette SHALL be an internal array of 2^IDX_W entries of COLOR_W bits.
REQ-015: rgb_out SHALL equal palette[obj_id] sampled one Clk earlier: fixed 1-cycle latency, updated every cycle.
REQ-016: On a same-cycle read and write of one index, rgb_out SHALL return the old value (read-before-write).
REQ-017: The FSM SHALL have exactly two states: IDLE and WRITE.
REQ-018: In IDLE, when vblank=1 and |wr_req=1, the FSM SHALL latch the granted requester's index, idx and rgb, then go to WRITE.
REQ-019: In IDLE with vblank=0 or wr_req=0, the FSM SHALL stay in IDLE.
REQ-020: In WRITE, the FSM SHALL write the latched rgb to palette[latched idx], assert wr_ack[grant] for that cycle only, record grant as last_grant, and return to IDLE.
REQ-021: Peak throughput SHALL be one write per two cycles.
REQ-022: Grant SHALL be round-robin: the first requesting index searched upward (with wrap) from last_grant+1 wins.
REQ-023: A requester SHALL hold wr_req, wr_idx and wr_rgb stable until it sees wr_ack, and SHALL drop wr_req in the following cycle.
REQ-024: The block SHALL ignore wr_req changes after latching.
REQ-025: A write latched before vblank falls SHALL still commit in WRITE, even if vblank=0 during that cycle.
REQ-026: No new grant SHALL occur while vblank=0; pending requests SHALL wait for the next vblank without ack.
REQ-027: wr_ack SHALL be derived from the registered state and grant only (glitch-free) and SHALL be zero outside WRITE.

Reset
REQ-028: While Reset=0 at a Clk edge, state SHALL go to IDLE, wr_ack to 0, busy to 0, rgb_out to 0, and last_grant to N_REQ-1 (requester 0 has first priority).
REQ-029: Reset SHALL load the palette with: [0]=3F007F, [1]=FFFFFF, [2]=FF0000, [3]=00FF00, [4]=FF00FF, all other entries 000000.
REQ-030: A reset asserted during WRITE SHALL abort the write: no palette change and no ack.

Structure
REQ-031: Package palette_pkg SHALL hold IDX_W, COLOR_W, the state enum (IDLE, WRITE) and the default-palette constant array.
REQ-032: The round-robin selection SHALL be a sub-module rr_arbiter, with inputs req[N_REQ] and last[$clog2(N_REQ)], and outputs grant index and valid.
REQ-033: Palette storage and the read register SHALL remain in palette_arbiter.

Verification
REQ-034: After reset, with obj_id=2 → rgb_out=FF0000 one cycle later; with obj_id=0 → 3F007F.
REQ-035: vblank=1, requester 0 writes idx 2 = 00FFFF → wr_ack=01 exactly one cycle; obj_id=2 then reads 00FFFF.
REQ-036: Both requesters hold req continuously in vblank → acks alternate 01,10,01,10, each separated by one idle cycle.
REQ-037: vblank=0, requester 1 requests → no ack and busy=0; vblank rises → ack within 2 cycles.
REQ-038: Latch occurs in the last vblank cycle → write commits and acks in the next cycle with vblank=0.
REQ-039: Reset pulsed during WRITE of idx 3 = 123456 → no ack, and entry 3 reads 00FF00.
